alu_uart_host: RTL
==================

Name: alu_uart_host

Overview:
Host-side sequencer for the UART ALU link: the initiator that talks to the ALU-side interface across the serial line. On a local request it sends three bytes through the UART transmitter in order: operand A, operand B, then the zero-extended opcode. It then waits for one result byte from the UART receiver and presents it with a one-cycle valid strobe. It sits between a stimulus/control source (test host, button logic, CPU) and a uart_tx/uart_rx pair.

Parameters:
DATA_SIZE, 8, width of operand, TX and RX bytes
OPCODE_SIZE, 6, width of opcode; zero-extended to DATA_SIZE on the line
TIMEOUT_CYCLES, 1000000, max cycles spent waiting for a TX completion or the RX result before aborting
TIMEOUT_WIDTH, 20, width of the timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_req  in  1  start a transaction; sampled only in IDLE
i_data_A  in  DATA_SIZE  operand A
i_data_B  in  DATA_SIZE  operand B
i_data_OPCODE  in  OPCODE_SIZE  ALU opcode
o_tx_start  out  1  one-cycle start pulse to uart_tx
o_tx_data  out  DATA_SIZE  byte to uart_tx
i_tx_done  in  1  byte-finished indication from uart_tx (pulse or level)
i_rx_done  in  1  byte-received indication from uart_rx (pulse or level)
i_rx_data  in  DATA_SIZE  received byte from uart_rx
o_busy  out  1  high whenever state != IDLE
o_result  out  DATA_SIZE  last received ALU result
o_result_valid  out  1  one-cycle pulse when o_result updates
o_timeout  out  1  one-cycle pulse when a transaction aborts
o_txn_count  out  8  number of successful transactions, wraps 255->0

Behaviour:
- Reset (synchronous, active-high; one clock, i_clk): state=IDLE. o_tx_start=0, o_tx_data=0, o_result=0, o_result_valid=0, o_timeout=0, o_txn_count=0, byte index=0, timeout counter=0.
- Reset also sets both edge-detect registers to 1, so a done input already high at reset release is not taken as an event. Reset mid-transaction aborts immediately with no timeout pulse.
- Edge detection: tx_ev = i_tx_done & ~last_tx_done; rx_ev = i_rx_done & ~last_rx_done. Both last_* registers update every cycle in every state.
- States: IDLE, SEND, WAIT_TX, WAIT_RX.
- IDLE: when i_req=1, latch A, B and {zeros, OPCODE} into internal byte registers, set index=0 and go to SEND. i_req in any other state is ignored and not queued.
- SEND (exactly one cycle): o_tx_start=1 and o_tx_data=byte[index]. Clear the timeout counter and go to WAIT_TX. o_tx_start goes high the cycle after i_req is sampled.
- o_tx_data holds its value from the SEND cycle until the next SEND or reset.
- WAIT_TX: on tx_ev, if index<2 then index+1 and go to SEND; if index==2, clear the timeout counter and go to WAIT_RX.
- rx_ev in SEND or WAIT_TX is ignored as stale.
- WAIT_RX: on rx_ev, register o_result<=i_rx_data, pulse o_result_valid, increment o_txn_count and go to IDLE. o_result holds until the next valid or reset.
- Timeout (WAIT_TX and WAIT_RX): the counter increments every cycle. If it equals TIMEOUT_CYCLES-1 and no event occurs that cycle, pulse o_timeout and go to IDLE. o_result and o_txn_count are unchanged.
- An event in the same cycle as the timeout limit wins; no timeout.
- Return-to-IDLE latency: o_result_valid (or o_timeout) is high in the cycle after the edge, and o_busy is already low in that same cycle. A new i_req can be accepted in that cycle.
- Minimum transaction length is 3×(1 SEND + 1 WAIT_TX) + 1 WAIT_RX cycles, plus the UART line time.

Test Plan:
- Normal: A=0x05, B=0x03, OP=0x20, tx_done 1-cycle pulses, then rx returns 0x08 -> tx bytes 0x05, 0x03, 0x20 each with one start pulse; o_result=0x08; o_result_valid one cycle; o_txn_count=1.
- Level done: i_tx_done and i_rx_done each held high 10 cycles, with i_rx_data=0xFF -> exactly 3 start pulses and 1 valid; no double-count; o_result=0xFF.
- Stale RX: rx_done pulse with i_rx_data=0xAA during WAIT_TX of byte B, then real result 0x11 -> 0xAA ignored; o_result=0x11.
- Timeout: TIMEOUT_CYCLES=64, no rx_done after the third byte -> o_timeout pulses 64 cycles into WAIT_RX; o_result keeps its previous value; o_txn_count unchanged; next request runs normally.
- Reset mid-op: assert i_reset during WAIT_TX of byte B -> next cycle all outputs 0, state IDLE, o_busy=0; a new req sends A first.
- Back-to-back and wrap: 256 transactions with i_req held high -> each request starts in the valid cycle of the previous one; o_txn_count wraps to 0.

Source files
------------

// File: rtl/alu_uart_host.sv
// Host-side sequencer for the UART ALU link: sends A, B and the opcode,
// then waits for the single result byte coming back from the ALU side.
module alu_uart_host #(
    parameter int DATA_SIZE      = 8,
    parameter int OPCODE_SIZE    = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req,
    input  logic [DATA_SIZE-1:0]   i_data_A,
    input  logic [DATA_SIZE-1:0]   i_data_B,
    input  logic [OPCODE_SIZE-1:0] i_data_OPCODE,
    output logic                   o_tx_start,
    output logic [DATA_SIZE-1:0]   o_tx_data,
    input  logic                   i_tx_done,
    input  logic                   i_rx_done,
    input  logic [DATA_SIZE-1:0]   i_rx_data,
    output logic                   o_busy,
    output logic [DATA_SIZE-1:0]   o_result,
    output logic                   o_result_valid,
    output logic                   o_timeout,
    output logic [7:0]             o_txn_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RX
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic [DATA_SIZE-1:0]     byte_a;
    logic [DATA_SIZE-1:0]     byte_b;
    logic [DATA_SIZE-1:0]     byte_op;
    logic [DATA_SIZE-1:0]     next_byte;
    logic [1:0]               idx;
    logic [1:0]               next_idx;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     last_tx_done;
    logic                     last_rx_done;
    logic                     tx_ev;
    logic                     rx_ev;
    logic                     tmo_hit;

    // Done inputs may be pulses or levels; only rising edges count.
    assign tx_ev    = i_tx_done & ~last_tx_done;
    assign rx_ev    = i_rx_done & ~last_rx_done;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign next_idx = idx + 2'd1;
    assign o_busy   = (state != IDLE);

    always_comb begin
        next_byte = byte_a;
        unique case (next_idx)
            2'd1:    next_byte = byte_b;
            2'd2:    next_byte = byte_op;
            default: next_byte = byte_a;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            byte_a         <= '0;
            byte_b         <= '0;
            byte_op        <= '0;
            idx            <= 2'd0;
            tmo_cnt        <= '0;
            last_tx_done   <= 1'b1;
            last_rx_done   <= 1'b1;
            o_tx_start     <= 1'b0;
            o_tx_data      <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            o_txn_count    <= 8'd0;
        end else begin
            last_tx_done   <= i_tx_done;
            last_rx_done   <= i_rx_done;
            o_tx_start     <= 1'b0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        byte_a     <= i_data_A;
                        byte_b     <= i_data_B;
                        byte_op    <= DATA_SIZE'(i_data_OPCODE);
                        idx        <= 2'd0;
                        // start and data are registered on entry so they
                        // are visible during the SEND cycle itself
                        o_tx_start <= 1'b1;
                        o_tx_data  <= i_data_A;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_ev) begin
                        if (idx < 2'd2) begin
                            idx        <= next_idx;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= next_byte;
                            state      <= SEND;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= WAIT_RX;
                        end
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                WAIT_RX: begin
                    if (rx_ev) begin
                        o_result       <= i_rx_data;
                        o_result_valid <= 1'b1;
                        o_txn_count    <= o_txn_count + 8'd1;
                        state          <= IDLE;
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
